picosoc_iomem_timer: RTL
========================

Name: picosoc_iomem_timer

Overview:
- Responder on the SoC's iomem bus: the target end of the CPU-side valid/ready memory handshake that leaves the SoC on iomem_*.
- Provides a memory-mapped 32-bit down-counting timer with prescaler, auto-reload, sticky expiry flag and a level interrupt intended for one of the SoC's external irq_5..irq_7 inputs.
- Sits outside the SoC top, in the 0x03xx_xxxx iomem window.

Parameters:
- BASE_ADDR, 32'h0300_0000, register window base; only bits [31:8] are compared.
- PRESCALE_W, 16, width of the PRESCALE register and the prescaler counter (1..32).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- iomem_valid  in  1  transaction request from CPU
- iomem_ready  out  1  transaction complete, one-cycle pulse
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- irq  out  1  level interrupt = STATUS.EXP & CTRL.IE
- capture_in  in  1  asynchronous capture strobe (used only with the optional feature)

Behaviour:
- Reset (async, resetn=0): iomem_ready=0, iomem_rdata=0, irq=0; all registers, the prescaler and the FSM clear to 0 / IDLE immediately, including mid-transaction.
- Select: sel = iomem_valid && iomem_addr[31:8]==BASE_ADDR[31:8]. Register offset = iomem_addr[7:2].
- Handshake FSM, 2 states:
  - IDLE: on sel, commit the write (byte-wise per wstrb) or capture read data at that edge, then go to ACK.
  - ACK: iomem_ready=1 for exactly one cycle, rdata held; always return to IDLE.
  - Latency is 1 cycle: ready rises the cycle after valid is first seen.
  - No new transaction is accepted while in ACK.
  - iomem_rdata returns to 0 in IDLE.
- Register map (offset, access):
  - 0x00 CTRL, RW: [0] EN, [1] AR (auto-reload), [2] IE; other bits read 0.
  - 0x04 PRESCALE, RW: [PRESCALE_W-1:0].
  - 0x08 COUNT, RW.
  - 0x0C RELOAD, RW.
  - 0x10 STATUS: [0] EXP, W1C; [1] CAP, W1C.
  - 0x14 CAPTURE, RO.
  - Unmapped offsets read 0, writes are ignored, and the access is still acked.
- Prescaler:
  - While EN=1, pcnt counts 0..PRESCALE; tick when pcnt==PRESCALE, then pcnt returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - A write that sets EN 0->1 clears pcnt.
  - While EN=0, pcnt holds 0.
- Counter, on each tick:
  - COUNT!=0: decrement by 1.
  - COUNT==0: set EXP. If AR=1, load RELOAD; otherwise clear EN and hold COUNT at 0.
  - Wrap-around never occurs, because a decrement from 0 is never performed.
- Simultaneous events:
  - A bus write to COUNT or CTRL in the same cycle as a tick wins over the tick.
  - A hardware set of EXP/CAP wins over a same-cycle W1C.
- irq is combinational from flops only; no bus path feeds it.

Optional Feature:
- Macro: PICOSOC_TIMER_CAPTURE_EN.
- Defined:
  - capture_in passes through a 2-flop synchroniser.
  - A synchronised rising edge copies COUNT into CAPTURE and sets STATUS.CAP.
  - A capture coincident with a COUNT bus write captures the pre-write value.
- Undefined:
  - capture_in is ignored.
  - CAPTURE and STATUS.CAP read 0; writes to them have no effect.

Test Plan:
- Bus handshake: read 0x0300_000C after reset → ready rises exactly 1 cycle after valid, for 1 cycle, rdata=0. A read of unmapped 0x0300_0040 → acked, rdata=0.
- Byte strobes: write 0x1122_3344 to RELOAD with wstrb=4'b0101, after reset → readback 0x0022_0044.
- One-shot: PRESCALE=3, COUNT=2, CTRL=0x5 → EXP and irq set after 12 cycles (3 ticks of 4 cycles each), EN reads 0, COUNT stays 0. A W1C of 0x1 to STATUS → irq=0.
- Auto-reload: PRESCALE=0, RELOAD=4, COUNT=0, CTRL=0x7 → EXP on the first tick, then COUNT sequence 4,3,2,1,0,4…. A W1C on the cycle EXP re-asserts → EXP stays 1.
- Collision and reset: a COUNT write of 0x100 on a tick cycle → reads 0x100, not 0xFF. resetn pulsed low during ACK → ready drops at once, all registers read 0 afterwards.
- Capture (macro defined): capture_in rises while COUNT=0x50 → CAPTURE=COUNT value 2–3 cycles later, STATUS=0x2. Macro undefined → CAPTURE reads 0.

Source files
------------

// File: rtl/picosoc_iomem_timer.sv
// iomem-bus responder with a prescaled 32-bit down-counting timer, auto-reload, sticky expiry and level irq.
// Optional capture input is enabled by defining PICOSOC_TIMER_CAPTURE_EN.
module picosoc_iomem_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
   parameter int          PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq,
   input  logic        capture_in
);

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t                  state, state_nxt;
   logic                    sel, acc, wr;
   logic                    wr_ctrl, wr_presc, wr_count, wr_reload, wr_status;
   logic [2:0]              ctrl;
   logic [PRESCALE_W-1:0]   prescale, pcnt;
   logic [31:0]             count, reload, capture;
   logic                    st_exp, st_cap;
   logic [31:0]             rd_val, wr_val;
   logic                    tick, exp_set;
   logic [5:0]              offset;
   logic                    unused_addr;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      return res;
   endfunction

   assign sel         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign offset      = iomem_addr[7:2];
   assign unused_addr = ^iomem_addr[1:0];

   always_comb begin
      state_nxt = state;
      acc       = 1'b0;
      case (state)
         IDLE: if (sel) begin
            acc       = 1'b1;
            state_nxt = ACK;
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign wr        = acc && (iomem_wstrb != 4'b0000);
   assign wr_ctrl   = wr && (offset == 6'h00);
   assign wr_presc  = wr && (offset == 6'h01);
   assign wr_count  = wr && (offset == 6'h02);
   assign wr_reload = wr && (offset == 6'h03);
   assign wr_status = wr && (offset == 6'h04);

   always_comb begin
      rd_val = '0;
      case (offset)
         6'h00:   rd_val[2:0] = ctrl;
         6'h01:   rd_val[PRESCALE_W-1:0] = prescale;
         6'h02:   rd_val = count;
         6'h03:   rd_val = reload;
         6'h04:   rd_val[1:0] = {st_cap, st_exp};
         6'h05:   rd_val = capture;
         default: rd_val = '0;
      endcase
      wr_val = byte_merge(rd_val, iomem_wdata, iomem_wstrb);
   end

   assign tick    = ctrl[0] && (pcnt == prescale);
   assign exp_set = tick && (count == 32'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         iomem_rdata <= '0;
         ctrl        <= '0;
         prescale    <= '0;
         pcnt        <= '0;
         count       <= '0;
         reload      <= '0;
         st_exp      <= 1'b0;
      end else begin
         state       <= state_nxt;
         iomem_rdata <= (acc && iomem_wstrb == 4'b0000) ? rd_val : 32'd0;

         // pcnt sits at 0 while disabled, so an EN 0->1 write always starts a fresh period
         if (!ctrl[0] || tick) pcnt <= '0;
         else                  pcnt <= pcnt + 1'b1;

         if (wr_ctrl)                 ctrl    <= wr_val[2:0];
         else if (exp_set && !ctrl[1]) ctrl[0] <= 1'b0;

         if (wr_presc)  prescale <= wr_val[PRESCALE_W-1:0];
         if (wr_reload) reload   <= wr_val;

         if (wr_count)               count <= wr_val;
         else if (tick) begin
            if (count != 32'd0)      count <= count - 32'd1;
            else if (ctrl[1])        count <= reload;
         end

         if (exp_set)                                             st_exp <= 1'b1;
         else if (wr_status && iomem_wstrb[0] && iomem_wdata[0])  st_exp <= 1'b0;
      end
   end

`ifdef PICOSOC_TIMER_CAPTURE_EN
   // two synchroniser flops plus one history flop for rising-edge detection
   logic [2:0] cap_sync;
   logic       cap_rise;

   assign cap_rise = cap_sync[1] & ~cap_sync[2];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_sync <= '0;
         capture  <= '0;
         st_cap   <= 1'b0;
      end else begin
         cap_sync <= {cap_sync[1:0], capture_in};
         if (cap_rise) begin
            capture <= count;
            st_cap  <= 1'b1;
         end else if (wr_status && iomem_wstrb[0] && iomem_wdata[1]) begin
            st_cap  <= 1'b0;
         end
      end
   end
`else
   logic unused_capture;
   assign unused_capture = capture_in;
   assign capture        = '0;
   assign st_cap         = 1'b0;
`endif

   assign iomem_ready = (state == ACK);
   assign irq         = st_exp & ctrl[2];

endmodule
